// File: rtl/dly_sequencer_pkg.sv
// Shared widths, the wait-for-done sentinel and the sequencer state encoding.
// State codes are fixed 3-bit values so benches and debug tools can decode them.
package dly_sequencer_pkg;

  localparam int OPR_W     = 5;
  localparam int ALU_TYP_W = 4;
  localparam int DLY_W     = 8;

  // Delay code that means "variable latency, commit on alu_done".
  localparam int DLY_WAIT  = 255;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LAUNCH    = 3'd1,
    ST_COUNT     = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_COMMIT    = 3'd4
  } seq_state_e;

endpackage

// File: rtl/dly_sequencer_if.sv
// Decoder-to-sequencer control bundle plus the timed actions handed back.
// The decoder side is the master; the sequencer is the slave.
interface dly_sequencer_if #(
  parameter int OPR_W     = dly_sequencer_pkg::OPR_W,
  parameter int ALU_TYP_W = dly_sequencer_pkg::ALU_TYP_W,
  parameter int DLY_W     = dly_sequencer_pkg::DLY_W
);

  logic                 issue;
  logic [OPR_W-1:0]     opr_typ_sel;
  logic                 alu_o_sel;
  logic                 alu_t_sel;
  logic [ALU_TYP_W-1:0] alu_typ_sel;
  logic                 src_dst_delay_sel;
  logic [DLY_W-1:0]     src_dst_delay;
  logic                 alu_done;
  logic                 abort;

  logic                 ready;
  logic                 alu_start;
  logic [ALU_TYP_W-1:0] alu_typ_q;
  logic [OPR_W-1:0]     opr_typ_q;
  logic                 commit;
  logic                 issue_drop;

  modport master (
    output issue, opr_typ_sel, alu_o_sel, alu_t_sel, alu_typ_sel,
           src_dst_delay_sel, src_dst_delay, alu_done, abort,
    input  ready, alu_start, alu_typ_q, opr_typ_q, commit, issue_drop
  );

  modport slave (
    input  issue, opr_typ_sel, alu_o_sel, alu_t_sel, alu_typ_sel,
           src_dst_delay_sel, src_dst_delay, alu_done, abort,
    output ready, alu_start, alu_typ_q, opr_typ_q, commit, issue_drop
  );

endinterface

// File: rtl/dly_counter.sv
// Launch-to-commit down-counter; saturates at zero and flags the last count.
module dly_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         is_one
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (en && (cnt != '0))
      cnt <= cnt - W'(1);
  end

  assign is_one = (cnt == W'(1));

endmodule

// File: rtl/dly_sequencer.sv
// Turns one decoded instruction at a time into ALU start, delay hold and a
// one-cycle commit pulse; sentinel delay waits on alu_done instead of counting.
module dly_sequencer #(
  parameter int OPR_W     = dly_sequencer_pkg::OPR_W,
  parameter int ALU_TYP_W = dly_sequencer_pkg::ALU_TYP_W,
  parameter int DLY_W     = dly_sequencer_pkg::DLY_W
) (
  input  logic           clk,
  input  logic           rst_n,
  dly_sequencer_if.slave bus
);
  import dly_sequencer_pkg::*;

  localparam logic [DLY_W-1:0] DLY_SENT = DLY_W'(DLY_WAIT);
  localparam logic [DLY_W-1:0] DLY_ONE  = DLY_W'(1);

  seq_state_e           state, state_nxt;
  logic [DLY_W-1:0]     dly_q, dly_eff;
  logic                 accept, cnt_load, cnt_en, cnt_is_one;
  logic                 ready_q, alu_start_q, commit_q, issue_drop_q;
  logic [ALU_TYP_W-1:0] alu_typ_q;
  logic [OPR_W-1:0]     opr_typ_q;

  // A zero delay would never reach the counter's is_one flag; run it as one.
  assign dly_eff = (bus.src_dst_delay == '0) ? DLY_ONE : bus.src_dst_delay;
  assign accept  = bus.issue && ready_q && !bus.abort;

  dly_counter #(.W(DLY_W)) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (dly_q - DLY_ONE),
    .en       (cnt_en),
    .is_one   (cnt_is_one)
  );

  always_comb begin
    state_nxt = state;
    cnt_load  = 1'b0;
    cnt_en    = 1'b0;
    case (state)
      ST_IDLE: state_nxt = ST_IDLE;
      ST_LAUNCH: begin
        cnt_load = 1'b1;
        if (dly_q == DLY_SENT)     state_nxt = ST_WAIT_DONE;
        else if (dly_q == DLY_ONE) state_nxt = ST_COMMIT;
        else                       state_nxt = ST_COUNT;
      end
      ST_COUNT: begin
        cnt_en = 1'b1;
        if (cnt_is_one) state_nxt = ST_COMMIT;
      end
      ST_WAIT_DONE: if (bus.alu_done) state_nxt = ST_COMMIT;
      ST_COMMIT:    state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
    if (accept)
      state_nxt = bus.src_dst_delay_sel ? ST_LAUNCH : ST_COMMIT;
    if (bus.abort)
      state_nxt = ST_IDLE;
  end

  // Outputs are registered from the next state, so an abort sampled on the
  // edge that would enter COMMIT cancels the pulse entirely.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      dly_q        <= '0;
      ready_q      <= 1'b1;
      alu_start_q  <= 1'b0;
      commit_q     <= 1'b0;
      issue_drop_q <= 1'b0;
      alu_typ_q    <= '0;
      opr_typ_q    <= '0;
    end else begin
      state        <= state_nxt;
      ready_q      <= (state_nxt == ST_IDLE) || (state_nxt == ST_COMMIT);
      commit_q     <= (state_nxt == ST_COMMIT);
      alu_start_q  <= accept && bus.src_dst_delay_sel && (bus.alu_o_sel || bus.alu_t_sel);
      issue_drop_q <= bus.issue && !ready_q && !bus.abort;
      if (accept) begin
        dly_q     <= dly_eff;
        alu_typ_q <= bus.alu_typ_sel;
        opr_typ_q <= bus.opr_typ_sel;
      end
    end
  end

  assign bus.ready      = ready_q;
  assign bus.alu_start  = alu_start_q;
  assign bus.commit     = commit_q;
  assign bus.issue_drop = issue_drop_q;
  assign bus.alu_typ_q  = alu_typ_q;
  assign bus.opr_typ_q  = opr_typ_q;

endmodule

// File: tb/tb_dly_sequencer.sv
// Directed scenarios for dly_sequencer plus a randomized run against a
// cycle-arithmetic reference model (commit cycle computed from accept + delay).
module tb_dly_sequencer;
  import dly_sequencer_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dly_sequencer_if #(.OPR_W(OPR_W), .ALU_TYP_W(ALU_TYP_W), .DLY_W(DLY_W)) bus ();

  dly_sequencer #(.OPR_W(OPR_W), .ALU_TYP_W(ALU_TYP_W), .DLY_W(DLY_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic                 rec_start  [0:63];
  logic                 rec_commit [0:63];
  logic                 rec_ready  [0:63];
  logic                 rec_drop   [0:63];
  logic [ALU_TYP_W-1:0] rec_alu    [0:63];
  logic [OPR_W-1:0]     rec_opr    [0:63];

  task automatic idle_inputs();
    bus.issue = 1'b0; bus.opr_typ_sel = '0; bus.alu_o_sel = 1'b0; bus.alu_t_sel = 1'b0;
    bus.alu_typ_sel = '0; bus.src_dst_delay_sel = 1'b0; bus.src_dst_delay = '0;
    bus.alu_done = 1'b0; bus.abort = 1'b0;
  endtask

  task automatic set_op(input logic [OPR_W-1:0] opr, input logic [ALU_TYP_W-1:0] alu,
                        input logic sel, input logic [DLY_W-1:0] d);
    bus.issue = 1'b1; bus.opr_typ_sel = opr; bus.alu_o_sel = 1'b1; bus.alu_t_sel = 1'b0;
    bus.alu_typ_sel = alu; bus.src_dst_delay_sel = sel; bus.src_dst_delay = d;
  endtask

  task automatic tick_rec(input int c);
    @(posedge clk); #1;
    rec_start[c] = bus.alu_start; rec_commit[c] = bus.commit; rec_ready[c] = bus.ready;
    rec_drop[c] = bus.issue_drop; rec_alu[c] = bus.alu_typ_q; rec_opr[c] = bus.opr_typ_q;
  endtask

  task automatic settle();
    idle_inputs();
    repeat (4) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    tick_rec(0);
    tick_rec(0);
    n_tests++;
    if ({rec_ready[0], rec_start[0], rec_commit[0], rec_drop[0], rec_alu[0], rec_opr[0]} !== {4'b1000, 9'd0}) begin
      n_fail++;
      $display("FAIL reset_values: got rdy=%0b st=%0b cm=%0b dr=%0b alu=%0d opr=%0d, required rdy=1 others 0",
               rec_ready[0], rec_start[0], rec_commit[0], rec_drop[0], rec_alu[0], rec_opr[0]);
    end
    rst_n = 1'b1;
    settle();
  endtask

  task automatic test_add();
    for (int c = 0; c < 12; c++) begin
      if (c == 0) set_op(5'd2, 4'd1, 1'b1, 8'd4); else bus.issue = 1'b0;
      tick_rec(c + 1);
    end
    for (int c = 1; c <= 12; c++) begin
      n_tests++;
      if (rec_start[c] !== (c == 1) || rec_commit[c] !== (c == 5)) begin
        n_fail++;
        $display("FAIL add_timing: cycle %0d start=%0b commit=%0b, required start=%0b commit=%0b",
                 c, rec_start[c], rec_commit[c], c == 1, c == 5);
      end
    end
    n_tests++;
    if (rec_alu[5] !== 4'd1 || rec_opr[5] !== 5'd2) begin
      n_fail++;
      $display("FAIL add_latch: alu_typ_q=%0d opr_typ_q=%0d, required 1 and 2", rec_alu[5], rec_opr[5]);
    end
    settle();
  endtask

  task automatic test_mul_sentinel();
    for (int c = 0; c < 46; c++) begin
      if (c == 0) set_op(5'd3, 4'd2, 1'b1, 8'd255); else bus.issue = 1'b0;
      bus.alu_done = (c == 0) || (c == 40);
      tick_rec(c + 1);
    end
    for (int c = 1; c <= 46; c++) begin
      n_tests++;
      if (rec_start[c] !== (c == 1) || rec_commit[c] !== (c == 41)) begin
        n_fail++;
        $display("FAIL mul_sentinel: cycle %0d start=%0b commit=%0b, required start=%0b commit=%0b",
                 c, rec_start[c], rec_commit[c], c == 1, c == 41);
      end
    end
    settle();
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 6; c++) begin
      if (c == 0)      set_op(5'd4, 4'd0, 1'b0, 8'd0);
      else if (c == 1) set_op(5'd2, 4'd1, 1'b1, 8'd1);
      else             bus.issue = 1'b0;
      tick_rec(c + 1);
    end
    for (int c = 1; c <= 6; c++) begin
      n_tests++;
      if (rec_start[c] !== (c == 2) || rec_commit[c] !== (c == 1 || c == 3)) begin
        n_fail++;
        $display("FAIL back_to_back: cycle %0d start=%0b commit=%0b, required start=%0b commit=%0b",
                 c, rec_start[c], rec_commit[c], c == 2, c == 1 || c == 3);
      end
    end
    n_tests++;
    if (rec_ready[1] !== 1'b1 || rec_opr[2] !== 5'd2) begin
      n_fail++;
      $display("FAIL b2b_ready: ready in commit=%0b opr_typ_q=%0d, required 1 and 2", rec_ready[1], rec_opr[2]);
    end
    settle();
  endtask

  task automatic test_drop();
    for (int c = 0; c < 12; c++) begin
      if (c == 0)      set_op(5'd6, 4'd3, 1'b1, 8'd7);
      else if (c == 3) set_op(5'd9, 4'd5, 1'b1, 8'd2);
      else             bus.issue = 1'b0;
      tick_rec(c + 1);
    end
    for (int c = 1; c <= 12; c++) begin
      n_tests++;
      if (rec_drop[c] !== (c == 4) || rec_commit[c] !== (c == 8)) begin
        n_fail++;
        $display("FAIL issue_drop: cycle %0d drop=%0b commit=%0b, required drop=%0b commit=%0b",
                 c, rec_drop[c], rec_commit[c], c == 4, c == 8);
      end
    end
    n_tests++;
    if (rec_opr[8] !== 5'd6) begin
      n_fail++;
      $display("FAIL drop_latch: opr_typ_q=%0d, required 6", rec_opr[8]);
    end
    settle();
  endtask

  task automatic test_abort();
    for (int c = 0; c < 30; c++) begin
      if (c == 0) set_op(5'd7, 4'd6, 1'b1, 8'd21); else bus.issue = 1'b0;
      bus.abort = (c == 10);
      tick_rec(c + 1);
    end
    for (int c = 1; c <= 30; c++) begin
      n_tests++;
      if (rec_commit[c] !== 1'b0 || rec_ready[c] !== (c >= 11) || rec_start[c] !== (c == 1)) begin
        n_fail++;
        $display("FAIL abort: cycle %0d commit=%0b ready=%0b start=%0b, required commit=0 ready=%0b start=%0b",
                 c, rec_commit[c], rec_ready[c], rec_start[c], c >= 11, c == 1);
      end
    end
    settle();
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 30; c++) begin
      if (c == 0)      set_op(5'd8, 4'd5, 1'b1, 8'd21);
      else if (c == 9) set_op(5'd1, 4'd1, 1'b1, 8'd3);
      else             bus.issue = 1'b0;
      rst_n = (c != 10);
      tick_rec(c + 1);
    end
    n_tests++;
    if (rec_alu[5] !== 4'd5 || rec_drop[10] !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_pre: alu_typ_q=%0d drop=%0b, required 5 and 1", rec_alu[5], rec_drop[10]);
    end
    n_tests++;
    if ({rec_ready[11], rec_start[11], rec_commit[11], rec_drop[11], rec_alu[11], rec_opr[11]} !== {4'b1000, 9'd0}) begin
      n_fail++;
      $display("FAIL reset_mid: got rdy=%0b st=%0b cm=%0b dr=%0b alu=%0d opr=%0d, required rdy=1 others 0",
               rec_ready[11], rec_start[11], rec_commit[11], rec_drop[11], rec_alu[11], rec_opr[11]);
    end
    for (int c = 11; c <= 30; c++) begin
      n_tests++;
      if (rec_commit[c] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_mid_commit: cycle %0d commit=%0b, required 0", c, rec_commit[c]);
      end
    end
    settle();
  endtask

  task automatic test_d0();
    for (int c = 0; c < 6; c++) begin
      if (c == 0) set_op(5'd2, 4'd1, 1'b1, 8'd0); else bus.issue = 1'b0;
      tick_rec(c + 1);
    end
    for (int c = 1; c <= 6; c++) begin
      n_tests++;
      if (rec_start[c] !== (c == 1) || rec_commit[c] !== (c == 2)) begin
        n_fail++;
        $display("FAIL d0_as_d1: cycle %0d start=%0b commit=%0b, required start=%0b commit=%0b",
                 c, rec_start[c], rec_commit[c], c == 1, c == 2);
      end
    end
    settle();
  endtask

  // Model: an accepted op knows its commit cycle (accept+1 for no-op,
  // accept+1+D for timed, done-edge+1 for sentinel); ready is "no op or op commits now".
  task automatic test_random();
    bit m_act, m_sent, rdy;
    int m_cc, m_lc, r;
    logic [OPR_W-1:0]     m_opr;
    logic [ALU_TYP_W-1:0] m_alu;
    logic [DLY_W-1:0]     d;
    int                   deff;
    logic e_ready, e_start, e_commit, e_drop;
    logic [12:0] got, exp_v;
    m_act = 1'b0; m_sent = 1'b0; m_cc = -1; m_lc = 0; m_opr = '0; m_alu = '0;
    for (int t = 0; t < 1500; t++) begin
      rst_n          = (t == 0) ? 1'b0 : ($urandom_range(0, 199) != 0);
      bus.abort      = ($urandom_range(0, 39) == 0);
      bus.alu_done   = ($urandom_range(0, 9) == 0);
      bus.issue      = ($urandom_range(0, 2) == 0);
      bus.opr_typ_sel = OPR_W'($urandom);
      bus.alu_typ_sel = ALU_TYP_W'($urandom);
      bus.alu_o_sel  = ($urandom_range(0, 1) == 1);
      bus.alu_t_sel  = ($urandom_range(0, 3) == 0);
      bus.src_dst_delay_sel = ($urandom_range(0, 4) != 0);
      r = $urandom_range(0, 9);
      if (r <= 5)      d = DLY_W'(r);
      else if (r <= 7) d = DLY_W'($urandom_range(6, 30));
      else if (r == 8) d = DLY_W'(DLY_WAIT);
      else             d = DLY_W'($urandom_range(31, 120));
      bus.src_dst_delay = d;

      if (!rst_n) begin
        m_act = 1'b0; m_opr = '0; m_alu = '0;
        e_ready = 1'b1; e_start = 1'b0; e_commit = 1'b0; e_drop = 1'b0;
      end else begin
        rdy = !m_act || (m_cc == t);
        e_drop = bus.issue && !rdy && !bus.abort;
        e_start = 1'b0;
        if (bus.abort) m_act = 1'b0;
        else begin
          if (m_act && m_sent && m_cc < 0 && t > m_lc && bus.alu_done) m_cc = t + 1;
          if (m_act && m_cc == t) m_act = 1'b0;
          if (bus.issue && rdy) begin
            m_act = 1'b1; m_lc = t + 1; m_opr = bus.opr_typ_sel; m_alu = bus.alu_typ_sel;
            if (!bus.src_dst_delay_sel) begin
              m_sent = 1'b0; m_cc = t + 1;
            end else begin
              e_start = bus.alu_o_sel || bus.alu_t_sel;
              deff = (d == '0) ? 1 : int'(d);
              if (deff == DLY_WAIT) begin m_sent = 1'b1; m_cc = -1; end
              else begin m_sent = 1'b0; m_cc = t + 1 + deff; end
            end
          end
        end
        e_commit = m_act && (m_cc == t + 1);
        e_ready  = !m_act || (m_cc == t + 1);
      end

      @(posedge clk); #1;
      got   = {bus.ready, bus.alu_start, bus.commit, bus.issue_drop, bus.alu_typ_q, bus.opr_typ_q};
      exp_v = {e_ready, e_start, e_commit, e_drop, m_alu, m_opr};
      n_tests++;
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL random: step %0d got {rdy,st,cm,dr,alu,opr}=%h, required %h", t, got, exp_v);
      end
    end
    rst_n = 1'b1;
    settle();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_add();
    test_mul_sentinel();
    test_back_to_back();
    test_drop();
    test_abort();
    test_reset_mid();
    test_d0();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dly_sequencer.md
# dly_sequencer

Execution-side sequencer that consumes the operand decoder's control bundle (operation type, ALU select/type, source-to-destination delay) and turns it into timed pipeline actions. It accepts one decoded instruction at a time, fires the ALU start strobe, holds the pipeline for the programmed delay, and emits a one-cycle commit (write-back) pulse. Delay code 255 marks variable-latency operations (MUL, DIV, SPLIT, DEG, RSHIFT); for these, commit follows the ALU's `alu_done`. The block sits between the decoder and the datapath/fetch stall logic.

## Interface
Parameters:
- `OPR_W`, 5, operation code width
- `ALU_TYP_W`, 4, ALU operation type width
- `DLY_W`, 8, delay field width; all-ones (255) is the "wait for done" sentinel

Ports:
- `clk`  in  1  single clock; all state changes on rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `issue`  in  1  decoded instruction valid this cycle
- `opr_typ_sel`  in  OPR_W  decoded operation code
- `alu_o_sel`, `alu_t_sel`  in  1 each  ALU operand fetch requests
- `alu_typ_sel`  in  ALU_TYP_W  ALU operation type
- `src_dst_delay_sel`  in  1  1 = delay field valid; 0 = no-op path
- `src_dst_delay`  in  DLY_W  cycles from launch to commit
- `alu_done`  in  1  ALU completion, used only for sentinel delay
- `abort`  in  1  flush (taken jump); cancels the in-flight instruction
- `ready`  out  1  can accept `issue` this cycle
- `alu_start`  out  1  one-cycle ALU launch strobe
- `alu_typ_q`  out  ALU_TYP_W  latched ALU type, held until next accept
- `opr_typ_q`  out  OPR_W  latched operation code, held until next accept
- `commit`  out  1  one-cycle write-back pulse
- `issue_drop`  out  1  one-cycle pulse: `issue` seen while `ready`=0

## Operation
- States: IDLE, LAUNCH, COUNT, WAIT_DONE, COMMIT.
- Accept is `issue && ready`. `ready` = 1 in IDLE and COMMIT only, so back-to-back issue is possible.
- On accept, latch `opr_typ_sel`, `alu_typ_sel`, `alu_o_sel|alu_t_sel` (the start flag) and the delay D.
- Transition on accept:
  - If `src_dst_delay_sel`=0, go to COMMIT. No `alu_start`.
  - Otherwise go to LAUNCH. D=0 is treated as D=1.
- LAUNCH behaviour:
  - `alu_start` = latched start flag.
  - Counter loads D-1.
  - Next state: WAIT_DONE if D=255, COMMIT if D=1, else COUNT.
- COUNT: decrement each cycle. When the counter reads 1, the next state is COMMIT.
- WAIT_DONE: stay until `alu_done`=1, then go to COMMIT. `alu_done` in any other state is ignored; no timeout.
- COMMIT: `commit`=1 for exactly one cycle. Then go to IDLE, or to the accept path if `issue` is present.
- Abort:
  - `abort`=1 in LAUNCH, COUNT, WAIT_DONE or COMMIT forces IDLE on the next edge.
  - `commit` is suppressed in an aborted COMMIT cycle.
  - Abort beats a simultaneous `issue`; that issue is not accepted and not counted as dropped.
- `issue_drop` fires when `issue`=1, `ready`=0 and `abort`=0.
- A `rst_n`=0 sample from any state, mid-count included, gives IDLE on that edge with all outputs at reset values.

## Timing
- All outputs are registered.
- Reset values: `ready`=1; `alu_start`, `commit`, `issue_drop` = 0; `alu_typ_q`, `opr_typ_q` = 0; state = IDLE; counter = 0.
- With the issue accepted at edge 0:
  - `alu_start` is high in cycle 1.
  - For 1≤D≤254, `commit` is high in cycle D+1.
  - On the no-op path, `commit` is high in cycle 1.
- Sentinel: with `alu_done` sampled high at edge k, `commit` is high in cycle k+1.
- Back-to-back: an issue accepted in a COMMIT cycle has its LAUNCH in the next cycle, with no bubble.

## Structure
- Shared package (`define.v`) holds `OPR_W`, `ALU_TYP_W`, `DLY_W`, a new `DLY_WAIT` = 255, and the state encoding constants (3-bit, for testbench visibility).
- One sub-module, `dly_counter`: a DLY_W down-counter with load, enable, and an `is_one` flag.
- The FSM and latches stay in `dly_sequencer`.

## Test plan
- Reset, then issue ADD (opr 2, alu_typ 1, sel 1, D=4) at cycle 0 → `alu_start` in cycle 1, `commit` in cycle 5, `alu_typ_q`=1.
- Issue MUL (D=255), `alu_done` at cycle 40 → `commit` in cycle 41 only; `alu_done` at cycle 0 is ignored.
- Issue MOV no-op (sel 0) → `commit` in cycle 1, no `alu_start`. A second issue (D=1) in cycle 1 → `alu_start` in cycle 2, `commit` in cycle 3.
- Issue D=7, extra `issue` at cycle 3 → `issue_drop` pulse in cycle 4, first op commits in cycle 8.
- Issue D=21, `abort` at cycle 10 → IDLE, `ready`=1 in cycle 11, no `commit`. Repeat with `rst_n`=0 at cycle 10 → all outputs at reset values in cycle 11.
- Issue D=0 with sel 1 → behaves as D=1, `commit` in cycle 2.
